// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the PC sequencer (mux selects, exception causes, sequencer states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // PC source mux selects
    localparam logic [2:0] PC_SRC_ALU    = 3'd0;
    localparam logic [2:0] PC_SRC_ALUOUT = 3'd1;
    localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
    localparam logic [2:0] PC_SRC_EPC    = 3'd3;
    localparam logic [2:0] PC_SRC_EXC    = 3'd4;

    // Exception cause; the value also selects the vector-table entry (cause - 1)
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_OPCODE   = 2'd1,
        CAUSE_OVERFLOW = 2'd2,
        CAUSE_DIV0     = 2'd3
    } exc_cause_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXC_SAVE = 2'd1,
        EXC_READ = 2'd2,
        EXC_LOAD = 2'd3
    } seq_state_e;

endpackage

// File: rtl/exc_vector_fetch.sv
// exc_vector_fetch: issues the vector-table read, waits MEM_LAT cycles, captures the handler address.
// Latency: start at edge N -> mem_read visible N+1..N+MEM_LAT, address latched at edge N+MEM_LAT.
// Backpressure: none; a new start while a fetch is running restarts the fetch.
// Ports: start (load address/counter), vec_addr (entry address), mem_data (read data),
//        mem_read/mem_addr (read request), exception_address (latched handler), done (last wait cycle).
module exc_vector_fetch #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] vec_addr,
    input  logic [31:0] mem_data,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] exception_address,
    output logic        done
);

    localparam int CW = 3;

    logic [CW-1:0] cnt;
    logic          unused_hi;

    // Only the low byte of a vector entry is meaningful; the handler lives in the first 256 bytes.
    assign unused_hi = ^mem_data[31:8];

    // Data is sampled on the edge that ends the cycle in which the counter shows 1.
    assign done = mem_read && (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read          <= 1'b0;
            mem_addr          <= '0;
            exception_address <= '0;
            cnt               <= '0;
        end else if (start) begin
            mem_read <= 1'b1;
            mem_addr <= vec_addr;
            cnt      <= CW'(MEM_LAT);
        end else if (mem_read) begin
            if (done) begin
                mem_read          <= 1'b0;
                exception_address <= {24'b0, mem_data[7:0]};
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: arbitrates PC-update requests and runs exception entry (save EPC, fetch vector, load PC).
// Latency: request at edge N drives registered outputs right after N; exception writes PC at edge N+3+MEM_LAT.
// Backpressure: none; requests and exceptions arriving while busy are dropped, not queued.
// Ports: req_* / exc_* from the main control FSM; pc_source, pc_write, epc_write to the PC/EPC registers;
//        mem_read, mem_addr, mem_data to the memory read port; exception_address, exc_cause, busy status.
module pc_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LAT  = 2,
    parameter int VEC_BASE = 253
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_inc,
    input  logic        req_branch,
    input  logic        branch_taken,
    input  logic        req_jump,
    input  logic        req_jr,
    input  logic        req_rte,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] mem_data,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] exception_address,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    seq_state_e  state_q, state_d;
    exc_cause_e  cause_q, cause_d;
    logic [2:0]  pc_source_d;
    logic        pc_write_d;
    logic        epc_write_d;
    logic        start_fetch;
    logic        fetch_done;
    logic [31:0] vec_addr;

    // cause_q is already valid in EXC_SAVE, when the fetch block loads this address.
    assign vec_addr  = 32'(VEC_BASE) + {30'b0, cause_q} - 32'd1;
    assign exc_cause = cause_q;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        pc_source_d = pc_source;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        start_fetch = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_opcode || exc_overflow || exc_div0) begin
                    state_d = EXC_SAVE;
                    if (exc_opcode)        cause_d = CAUSE_OPCODE;
                    else if (exc_overflow) cause_d = CAUSE_OVERFLOW;
                    else                   cause_d = CAUSE_DIV0;
                end else if (req_rte) begin
                    pc_source_d = PC_SRC_EPC;
                    pc_write_d  = 1'b1;
                end else if (req_jump) begin
                    pc_source_d = PC_SRC_JUMP;
                    pc_write_d  = 1'b1;
                end else if (req_jr) begin
                    pc_source_d = PC_SRC_ALU;
                    pc_write_d  = 1'b1;
                end else if (req_branch && branch_taken) begin
                    pc_source_d = PC_SRC_ALUOUT;
                    pc_write_d  = 1'b1;
                end else if (req_inc) begin
                    // An untaken branch is not a write, so a coincident increment lands here.
                    pc_source_d = PC_SRC_ALU;
                    pc_write_d  = 1'b1;
                end
            end
            EXC_SAVE: begin
                epc_write_d = 1'b1;
                start_fetch = 1'b1;
                state_d     = EXC_READ;
            end
            EXC_READ: begin
                if (fetch_done) state_d = EXC_LOAD;
            end
            EXC_LOAD: begin
                pc_source_d = PC_SRC_EXC;
                pc_write_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cause_q   <= CAUSE_NONE;
            pc_source <= PC_SRC_ALU;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            pc_source <= pc_source_d;
            pc_write  <= pc_write_d;
            epc_write <= epc_write_d;
            busy      <= (state_d != IDLE);
        end
    end

    exc_vector_fetch #(
        .MEM_LAT (MEM_LAT)
    ) u_fetch (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start_fetch),
        .vec_addr          (vec_addr),
        .mem_data          (mem_data),
        .mem_read          (mem_read),
        .mem_addr          (mem_addr),
        .exception_address (exception_address),
        .done              (fetch_done)
    );

endmodule
